// File: rtl/ysyx_22040632_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040632_pkg
// Description : Shared types and constants for the ysyx_22040632 sequencer.
//               - seq_state_e : sequencer FSM states (3-bit encoding)
//               - halt_code_e : reason reported on halt_code
//               - NOP_INST    : instruction value held after reset
//               - XLEN        : architectural register / PC width
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040632_pkg;

   localparam int          XLEN     = 64;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_FETCH_REQ  = 3'd0,
      S_FETCH_WAIT = 3'd1,
      S_DECODE     = 3'd2,
      S_EXEC       = 3'd3,
      S_WB         = 3'd4,
      S_HALT       = 3'd5
   } seq_state_e;

   typedef enum logic [1:0] {
      HC_RUN     = 2'd0,
      HC_EBREAK  = 2'd1,
      HC_ILLEGAL = 2'd2,
      HC_TIMEOUT = 2'd3
   } halt_code_e;

endpackage : ysyx_22040632_pkg
`default_nettype wire

// File: rtl/ysyx_22040632_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040632_watchdog
// Description : 8-bit clear/increment counter with terminal-count compare.
//               Clear has priority over increment.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               i_clr     - synchronous clear to zero
//               i_inc     - increment by one
//               o_tc      - count currently equals TERMINAL
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040632_watchdog #(
   parameter logic [7:0] TERMINAL = 8'd254
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (i_clr) begin
         r_cnt <= 8'd0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_tc = (r_cnt == TERMINAL);

endmodule : ysyx_22040632_watchdog
`default_nettype wire

// File: rtl/ysyx_22040632_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040632_seq_ctrl
// Description : Multi-cycle instruction sequencer. Owns the PC, performs the
//               instruction-memory fetch handshake and steps each instruction
//               through DECODE, EXEC (variable latency) and WB. Detects halt
//               conditions and counts retired instructions.
// Ports       : imem_req_valid/ready, imem_addr    - fetch request
//               imem_rsp_valid/data                - fetch response
//               inst                               - latched instruction
//               dec_illegal, dec_ebreak            - decoder flags (DECODE)
//               exu_start, exu_rdy, exu_redirect,
//               exu_target                         - EXU handshake
//               wb_en                              - register-file write strobe
//               pc, halt, halt_code, retire_cnt    - status
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040632_seq_ctrl
   import ysyx_22040632_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h8000_0000,
   parameter int          EXU_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] inst,
   input  logic        dec_illegal,
   input  logic        dec_ebreak,
   output logic        exu_start,
   input  logic        exu_rdy,
   input  logic        exu_redirect,
   input  logic [63:0] exu_target,
   output logic        wb_en,
   output logic [63:0] pc,
   output logic        halt,
   output logic [1:0]  halt_code,
   output logic [63:0] retire_cnt
);

   // The watchdog reads 0 in the first EXEC cycle, so the EXU_TIMEOUT-th
   // EXEC cycle is the one where the count equals EXU_TIMEOUT-1. The value
   // is clamped into the 8-bit counter range.
   localparam int c_TC_INT = (EXU_TIMEOUT < 1)   ? 0   :
                             (EXU_TIMEOUT > 256) ? 255 : (EXU_TIMEOUT - 1);
   localparam logic [7:0] c_TC = 8'(c_TC_INT);

   seq_state_e      r_state;
   halt_code_e      r_halt_code;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_next_pc;
   logic [XLEN-1:0] r_retire;
   logic [31:0]     r_inst;
   logic            r_exu_start;

   logic            w_wd_clr;
   logic            w_wd_inc;
   logic            w_wd_tc;
   logic [XLEN-1:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 64'd4;

   // Clearing throughout DECODE guarantees a zero count on EXEC entry.
   assign w_wd_clr = (r_state == S_DECODE);
   assign w_wd_inc = (r_state == S_EXEC) && !exu_rdy;

   ysyx_22040632_watchdog #(
      .TERMINAL (c_TC)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_wd_clr),
      .i_inc (w_wd_inc),
      .o_tc  (w_wd_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH_REQ;
         r_halt_code <= HC_RUN;
         r_pc        <= RESET_PC;
         r_next_pc   <= RESET_PC;
         r_retire    <= '0;
         r_inst      <= NOP_INST;
         r_exu_start <= 1'b0;
      end else begin
         r_exu_start <= 1'b0;
         case (r_state)
            S_FETCH_REQ: begin
               if (imem_req_ready) begin
                  r_state <= S_FETCH_WAIT;
               end
            end
            S_FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  r_inst  <= imem_rsp_data;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (dec_illegal) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HC_ILLEGAL;
               end else if (dec_ebreak) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HC_EBREAK;
                  r_retire    <= r_retire + 64'd1;
               end else begin
                  r_state     <= S_EXEC;
                  r_exu_start <= 1'b1;
               end
            end
            S_EXEC: begin
               // A result arriving on the timeout cycle still completes.
               if (exu_rdy) begin
                  r_next_pc <= exu_redirect ? exu_target : w_pc_plus4;
                  r_state   <= S_WB;
               end else if (w_wd_tc) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HC_TIMEOUT;
               end
            end
            S_WB: begin
               r_pc     <= r_next_pc;
               r_retire <= r_retire + 64'd1;
               r_state  <= S_FETCH_REQ;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   assign imem_req_valid = (r_state == S_FETCH_REQ);
   assign imem_addr      = r_pc;
   assign inst           = r_inst;
   assign exu_start      = r_exu_start;
   assign wb_en          = (r_state == S_WB);
   assign pc             = r_pc;
   assign halt           = (r_state == S_HALT);
   assign halt_code      = r_halt_code;
   assign retire_cnt     = r_retire;

endmodule : ysyx_22040632_seq_ctrl
`default_nettype wire

// File: tb/tb_ysyx_22040632_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040632_seq_ctrl
// Description : Scoreboard bench for the instruction sequencer. The driver
//               walks one instruction at a time through the handshakes and
//               pushes the expected fetch addresses, EXU launches, writebacks
//               and halts into queues; an independent monitor pops and
//               compares whenever the DUT presents the matching event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040632_seq_ctrl;

   localparam logic [63:0] c_RESET_PC = 64'h8000_0000;
   localparam int          c_TIMEOUT  = 255;
   localparam logic [31:0] c_NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] inst;
   logic        dec_illegal;
   logic        dec_ebreak;
   logic        exu_start;
   logic        exu_rdy;
   logic        exu_redirect;
   logic [63:0] exu_target;
   logic        wb_en;
   logic [63:0] pc;
   logic        halt;
   logic [1:0]  halt_code;
   logic [63:0] retire_cnt;

   ysyx_22040632_seq_ctrl #(
      .RESET_PC    (c_RESET_PC),
      .EXU_TIMEOUT (c_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst           (inst),
      .dec_illegal    (dec_illegal),
      .dec_ebreak     (dec_ebreak),
      .exu_start      (exu_start),
      .exu_rdy        (exu_rdy),
      .exu_redirect   (exu_redirect),
      .exu_target     (exu_target),
      .wb_en          (wb_en),
      .pc             (pc),
      .halt           (halt),
      .halt_code      (halt_code),
      .retire_cnt     (retire_cnt)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] ret;
   } wb_t;

   typedef struct {
      logic [1:0]  code;
      logic [63:0] ret;
      logic [63:0] pc;
   } halt_t;

   logic [63:0] q_fetch[$];
   logic [63:0] q_start[$];
   wb_t         q_wb[$];
   halt_t       q_halt[$];

   // Reference model state: architectural view only.
   logic [63:0] m_pc;
   logic [63:0] m_ret;
   logic [31:0] m_inst;

   int n_cmp;
   int n_bad;
   int cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin
      wb_t   w;
      halt_t h;
      logic  prev_halt;
      logic [63:0] a;
      prev_halt = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_halt = 1'b0;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               if (q_fetch.size() == 0) begin
                  chk("unexpected_fetch", imem_addr, 64'hDEAD_DEAD_DEAD_DEAD);
               end else begin
                  a = q_fetch.pop_front();
                  chk("fetch_addr", imem_addr, a);
               end
            end
            if (exu_start) begin
               if (q_start.size() == 0) begin
                  chk("unexpected_exu_start", 64'(exu_start), 64'd0);
               end else begin
                  a = q_start.pop_front();
                  chk("exu_start_pc", pc, a);
               end
            end
            if (wb_en) begin
               if (q_wb.size() == 0) begin
                  chk("unexpected_wb_en", 64'(wb_en), 64'd0);
               end else begin
                  w = q_wb.pop_front();
                  chk("wb_pc", pc, w.pc);
                  chk("wb_inst", 64'(inst), 64'(w.inst));
                  chk("wb_retire_before", retire_cnt, w.ret);
               end
            end
            if (halt && !prev_halt) begin
               if (q_halt.size() == 0) begin
                  chk("unexpected_halt", 64'(halt), 64'd0);
               end else begin
                  h = q_halt.pop_front();
                  chk("halt_code", 64'(halt_code), 64'(h.code));
                  chk("halt_retire", retire_cnt, h.ret);
                  chk("halt_pc", pc, h.pc);
               end
            end
            if (halt) begin
               chk("halted_outputs_quiet", 64'({imem_req_valid, exu_start, wb_en}), 64'd0);
            end
            prev_halt = halt;
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      dec_illegal    = 1'b0;
      dec_ebreak     = 1'b0;
      exu_rdy        = 1'b0;
      exu_redirect   = 1'b0;
      exu_target     = 64'd0;
      tick();
      tick();
      q_fetch.delete();
      q_start.delete();
      q_wb.delete();
      q_halt.delete();
      m_pc   = c_RESET_PC;
      m_ret  = 64'd0;
      m_inst = c_NOP;
      rst    = 1'b0;
      #1;
      chk("rst_pc", pc, c_RESET_PC);
      chk("rst_inst", 64'(inst), 64'(c_NOP));
      chk("rst_retire", retire_cnt, 64'd0);
      chk("rst_halt", 64'({halt, halt_code}), 64'd0);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
      chk("rst_start_wb", 64'({exu_start, wb_en}), 64'd0);
   endtask

   // kind: 0 normal, 1 ebreak, 2 illegal, 3 illegal+ebreak.
   // lat : EXEC cycles without exu_rdy before the result cycle.
   // abort_at > 0: assert rst after that many EXEC cycles (needs lat > abort_at).
   task automatic run_instr(input int rd, input int sd, input int lat,
                            input logic redir, input logic [63:0] tgt,
                            input logic [31:0] data, input int kind,
                            input int abort_at);
      wb_t         w;
      halt_t       h;
      logic [31:0] prev_inst;
      int          guard;
      prev_inst = m_inst;
      q_fetch.push_back(m_pc);
      guard = 0;
      while (!imem_req_valid && guard < 20) begin
         tick();
         guard++;
      end
      chk("req_valid_wait", 64'(imem_req_valid), 64'd1);
      // FETCH_REQ stall, stray response/result inputs must be ignored
      for (int i = 0; i < rd; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         exu_rdy        = 1'($urandom_range(0, 1));
         tick();
         chk("addr_stable", imem_addr, m_pc);
      end
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      tick();
      imem_req_ready = 1'b0;
      // FETCH_WAIT
      for (int i = 0; i < sd; i++) begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         exu_rdy        = 1'($urandom_range(0, 1));
         dec_illegal    = 1'($urandom_range(0, 1));
         dec_ebreak     = 1'($urandom_range(0, 1));
         tick();
         chk("inst_hold", 64'(inst), 64'(prev_inst));
      end
      dec_illegal    = 1'b0;
      dec_ebreak     = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      chk("inst_capture", 64'(inst), 64'(data));
      m_inst = data;
      // DECODE
      dec_illegal = (kind >= 2);
      dec_ebreak  = (kind == 1) || (kind == 3);
      exu_rdy     = 1'($urandom_range(0, 1));
      if (kind >= 2) begin
         h.code = 2'd2; h.ret = m_ret; h.pc = m_pc;
         q_halt.push_back(h);
      end else if (kind == 1) begin
         m_ret  = m_ret + 64'd1;
         h.code = 2'd1; h.ret = m_ret; h.pc = m_pc;
         q_halt.push_back(h);
      end else begin
         q_start.push_back(m_pc);
      end
      tick();
      dec_illegal = 1'b0;
      dec_ebreak  = 1'b0;
      if (kind != 0) begin
         chk("halt_after_decode", 64'(halt), 64'd1);
         return;
      end
      chk("exu_start_first_exec", 64'(exu_start), 64'd1);
      // EXEC
      if (lat >= c_TIMEOUT) begin
         h.code = 2'd3; h.ret = m_ret; h.pc = m_pc;
         q_halt.push_back(h);
         for (int i = 0; i < c_TIMEOUT; i++) begin
            exu_rdy        = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            if (i == c_TIMEOUT - 1) chk("halt_not_early", 64'(halt), 64'd0);
            tick();
         end
         imem_rsp_valid = 1'b0;
         chk("halt_after_timeout", 64'(halt), 64'd1);
         return;
      end
      for (int i = 0; i < lat; i++) begin
         if (abort_at > 0 && i == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_no_wb", 64'(wb_en), 64'd0);
            tick();
            chk("abort_no_wb_hold", 64'(wb_en), 64'd0);
            tick();
            q_fetch.delete();
            q_start.delete();
            q_wb.delete();
            q_halt.delete();
            m_pc   = c_RESET_PC;
            m_ret  = 64'd0;
            m_inst = c_NOP;
            rst    = 1'b0;
            exu_rdy = 1'b0;
            #1;
            chk("abort_retire", retire_cnt, 64'd0);
            chk("abort_pc", imem_addr, c_RESET_PC);
            return;
         end
         exu_rdy        = 1'b0;
         exu_redirect   = 1'($urandom_range(0, 1));
         exu_target     = {$urandom, $urandom};
         imem_rsp_valid = 1'($urandom_range(0, 1));
         tick();
         chk("exu_start_single", 64'(exu_start), 64'd0);
      end
      imem_rsp_valid = 1'b0;
      w.pc = m_pc; w.inst = data; w.ret = m_ret;
      q_wb.push_back(w);
      m_pc  = redir ? tgt : (m_pc + 64'd4);
      m_ret = m_ret + 64'd1;
      exu_rdy      = 1'b1;
      exu_redirect = redir;
      exu_target   = tgt;
      tick();
      // WB: stray result inputs
      exu_rdy      = 1'($urandom_range(0, 1));
      exu_redirect = 1'($urandom_range(0, 1));
      exu_target   = {$urandom, $urandom};
      tick();
      exu_rdy = 1'b0;
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      int t0;
      logic [63:0] tgt;
      n_cmp = 0;
      n_bad = 0;
      do_reset();

      // back-to-back, all ready immediately, sequential PCs, 5-cycle cadence
      run_instr(0, 0, 0, 1'b0, 64'd0, 32'h0010_0093, 0, 0);
      t0 = cyc;
      run_instr(0, 0, 0, 1'b0, 64'd0, 32'h0020_0113, 0, 0);
      chk("cadence_2", 64'(cyc - t0), 64'd5);
      t0 = cyc;
      run_instr(0, 0, 0, 1'b0, 64'd0, 32'h0030_0193, 0, 0);
      chk("cadence_3", 64'(cyc - t0), 64'd5);
      chk("retire_after_3", retire_cnt, 64'd3);
      chk("pc_after_3", pc, 64'h8000_000C);

      // stalled request and delayed response
      run_instr(4, 3, 0, 1'b0, 64'd0, 32'h00a0_0093, 0, 0);

      // long EXU latency with redirect
      run_instr(0, 0, 10, 1'b1, 64'h8000_0100, 32'h0000_006f, 0, 0);
      chk("redirect_pc", pc, 64'h8000_0100);

      // misaligned target loaded unchanged
      run_instr(1, 1, 2, 1'b1, 64'h8000_0102, $urandom, 0, 0);
      chk("misaligned_pc", pc, 64'h8000_0102);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         tgt = {$urandom, $urandom};
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12),
                   1'($urandom_range(0, 1)), tgt, $urandom, 0, 0);
      end
      chk("retire_random", retire_cnt, m_ret);

      // PC wrap
      run_instr(0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, $urandom, 0, 0);
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 0, 0);
      chk("pc_wrap", pc, 64'd0);
      run_instr(0, 0, 1, 1'b0, 64'd0, $urandom, 0, 0);

      // ebreak on the third instruction, then stray inputs while halted
      do_reset();
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 0, 0);
      run_instr(1, 0, 1, 1'b0, 64'd0, $urandom, 0, 0);
      run_instr(0, 1, 0, 1'b0, 64'd0, 32'h0010_0073, 1, 0);
      for (int i = 0; i < 10; i++) begin
         imem_req_ready = 1'b1;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = $urandom;
         exu_rdy        = 1'b1;
         exu_redirect   = 1'b1;
         dec_ebreak     = 1'($urandom_range(0, 1));
         tick();
      end
      chk("ebreak_retire", retire_cnt, 64'd3);
      chk("ebreak_code", 64'(halt_code), 64'd1);
      chk("ebreak_pc_frozen", pc, 64'h8000_0008);
      chk("ebreak_inst_frozen", 64'(inst), 64'h0010_0073);

      // illegal has priority over ebreak
      do_reset();
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 3, 0);
      chk("illegal_retire", retire_cnt, 64'd0);

      // EXU never ready: timeout
      do_reset();
      run_instr(0, 0, c_TIMEOUT, 1'b0, 64'd0, $urandom, 0, 0);

      // exu_rdy on exactly the timeout cycle completes normally
      do_reset();
      run_instr(0, 0, c_TIMEOUT - 1, 1'b0, 64'd0, $urandom, 0, 0);
      chk("rdy_at_timeout_halt", 64'(halt), 64'd0);
      chk("rdy_at_timeout_retire", retire_cnt, 64'd1);
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 0, 0);

      // reset during EXEC aborts the instruction
      do_reset();
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 0, 0);
      run_instr(0, 0, 8, 1'b0, 64'd0, $urandom, 0, 3);
      run_instr(0, 0, 0, 1'b0, 64'd0, $urandom, 0, 0);
      chk("post_abort_pc", pc, 64'h8000_0004);

      tick();
      chk("left_fetch", 64'(q_fetch.size()), 64'd0);
      chk("left_start", 64'(q_start.size()), 64'd0);
      chk("left_wb", 64'(q_wb.size()), 64'd0);
      chk("left_halt", 64'(q_halt.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit exceeded");
   end

endmodule : tb_ysyx_22040632_seq_ctrl
`default_nettype wire

// File: doc/ysyx_22040632_seq_ctrl.md
# ysyx_22040632_seq_ctrl

Multi-cycle instruction sequencer for the ysyx_22040632 core. It owns the PC and drives the instruction-memory fetch handshake, then steps each instruction through decode, execute (variable-latency EXU) and writeback, one at a time. It detects halt conditions (ebreak, illegal instruction, EXU timeout) and counts retired instructions. It sits in the top level between instruction memory and the IDU/EXU pair, replacing free-running PC stepping.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000: PC value loaded on reset.
- EXU_TIMEOUT, 255: maximum cycles spent in EXEC waiting for exu_rdy before the block halts; 8-bit counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  64  fetch address; equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- inst  out  32  latched instruction to the IDU.
- dec_illegal  in  1  IDU flags inst as undecodable; sampled in DECODE.
- dec_ebreak  in  1  IDU flags inst as ebreak; sampled in DECODE.
- exu_start  out  1  one-cycle pulse that launches the EXU.
- exu_rdy  in  1  EXU result valid.
- exu_redirect  in  1  branch/jump taken; qualified by exu_rdy.
- exu_target  in  64  redirect target; qualified by exu_rdy and exu_redirect.
- wb_en  out  1  one-cycle register-file write strobe.
- pc  out  64  current instruction address.
- halt  out  1  sticky halt flag.
- halt_code  out  2  0 = running, 1 = ebreak, 2 = illegal, 3 = EXU timeout.
- retire_cnt  out  64  count of retired instructions.

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB, HALT.
- FETCH_REQ: imem_req_valid=1. If imem_req_ready=1, go to FETCH_WAIT. Otherwise hold; imem_addr stays stable.
- FETCH_WAIT: imem_req_valid=0. When imem_rsp_valid=1, latch imem_rsp_data into inst and go to DECODE.
- DECODE: one cycle. Evaluated in priority order:
  - dec_illegal=1: HALT, code 2.
  - dec_ebreak=1: HALT, code 1. ebreak counts as retired.
  - otherwise: EXEC with exu_start=1 on the entry edge.
- EXEC: an 8-bit wait counter clears on entry.
  - exu_rdy=1: go to WB. Latch next_pc = exu_redirect ? exu_target : pc+4.
  - Otherwise the counter increments. When it reaches EXU_TIMEOUT with exu_rdy still 0: HALT, code 3.
  - If exu_rdy arrives in the same cycle as the timeout, exu_rdy wins.
- WB: wb_en=1 for exactly one cycle. Same edge: pc <= next_pc, retire_cnt += 1, go to FETCH_REQ.
- PC arithmetic is modulo 2^64: pc+4 wraps. retire_cnt also wraps.
- exu_target[1:0] != 0 is not checked; it is loaded as given.
- HALT: terminal until rst. imem_req_valid=0, exu_start=0, wb_en=0. pc, inst and retire_cnt are frozen.
- Inputs arriving in states that do not sample them are ignored: imem_rsp_valid outside FETCH_WAIT, exu_rdy outside EXEC.

## Timing
- Reset values: state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), retire_cnt=0, halt=0, halt_code=0, imem_req_valid=1, exu_start=0, wb_en=0.
- Reset asserted mid-instruction aborts it immediately: no wb_en, no retire increment. The first request after release uses RESET_PC.
- All outputs are registered or derived from state only. No combinational path from inputs to outputs.
- Minimum instruction latency, with ready/rsp/exu_rdy each in the first cycle possible, is 5 cycles: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB.
- exu_start asserts in the first EXEC cycle only. exu_rdy is accepted in that same cycle.
- halt and halt_code assert on the cycle after the causing condition and stay asserted.

## Structure
- Shared package ysyx_22040632_pkg:
  - seq_state_e enum (3 bits).
  - halt_code_e enum.
  - localparam NOP_INST = 32'h0000_0013.
  - localparam XLEN = 64.
- One sub-module is natural: ysyx_22040632_watchdog, an 8-bit clear/increment counter with a terminal-count compare, used for the EXEC timeout.
- The FSM, PC and retire counter stay in this module.

## Test plan
- Reset then back-to-back fetch, all handshakes ready immediately, exu_redirect=0: pc steps 8000_0000 -> 8000_0004 -> 8000_0008. wb_en pulses every 5 cycles. retire_cnt=3 after 15 cycles.
- imem_req_ready held low 4 cycles, then imem_rsp_valid delayed 3 cycles: imem_addr stable throughout. inst captures 32'h00a0_0093 only on the rsp cycle.
- EXU returns exu_rdy after 10 cycles with exu_redirect=1, exu_target=8000_0100: exactly one exu_start pulse. Next imem_addr = 8000_0100.
- dec_ebreak=1 on the third instruction: halt=1, halt_code=1, retire_cnt=3. No further imem_req_valid, even with stray rsp/rdy inputs.
- exu_rdy never asserted: halt_code=3 after EXU_TIMEOUT EXEC cycles. Repeat with exu_rdy on exactly the timeout cycle: no halt, WB occurs.
- rst asserted during EXEC and released 2 cycles later: no wb_en, retire_cnt=0, next fetch address 8000_0000. pc=FFFF_FFFF_FFFF_FFFC with no redirect wraps to 0.
